// File: rtl/serial_add_sub_pkg.sv
// Shared constants and FSM encoding for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    SAS_IDLE = 2'b00,
    SAS_RUN  = 2'b01,
    SAS_FIN  = 2'b10
  } sas_state_e;

endpackage

// File: rtl/serial_add_sub_if.sv
// Request/result bundle of the serial adder; master issues operands, slave returns results.
interface serial_add_sub_if
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
);
  logic             start;
  logic             sna;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             co;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, sna, a, b,
    input  y, co, ovf, busy, done
  );

  modport slave (
    input  start, sna, a, b,
    output y, co, ovf, busy, done
  );
endinterface

// File: rtl/serial_add_sub_fa.sv
// One-bit full adder; the only arithmetic cell of the serial datapath.
module serial_add_sub_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit per clock, LSB first, registered carry.
// Subtraction is A + ~B + 1, with the +1 injected as the initial carry.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  serial_add_sub_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);

  sas_state_e       state_r;
  sas_state_e       state_nxt_s;
  logic             load_s;
  logic             step_s;
  logic             last_s;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH-2:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             cmsb_r;
  logic             fa_sum_s;
  logic             fa_co_s;
  logic [WIDTH-1:0] y_r;
  logic             co_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  assign bus.y    = y_r;
  assign bus.co   = co_r;
  assign bus.ovf  = ovf_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

  serial_add_sub_fa fa_inst (
    .a  (opa_r[0]),
    .b  (opb_r[0]),
    .ci (carry_r),
    .s  (fa_sum_s),
    .co (fa_co_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= SAS_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and datapath strobes
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      SAS_IDLE: begin
        if (bus.start) begin
          load_s      = 1'b1;
          state_nxt_s = SAS_RUN;
        end else begin
          state_nxt_s = SAS_IDLE;
        end
      end
      SAS_RUN: begin
        step_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          last_s      = 1'b1;
          state_nxt_s = SAS_FIN;
        end else begin
          state_nxt_s = SAS_RUN;
        end
      end
      SAS_FIN:  state_nxt_s = SAS_IDLE;
      default:  state_nxt_s = SAS_IDLE;
    endcase
  end

  // Operand shifters, accumulator, carry chain and registered results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa_r   <= '0;
      opb_r   <= '0;
      acc_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      cmsb_r  <= 1'b0;
      y_r     <= '0;
      co_r    <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (load_s) begin
      opa_r   <= bus.a;
      opb_r   <= bus.sna ? ~bus.b : bus.b;
      carry_r <= bus.sna;
      cnt_r   <= '0;
      busy_r  <= 1'b1;
    end else if (step_s) begin
      opa_r   <= {1'b0, opa_r[WIDTH-1:1]};
      opb_r   <= {1'b0, opb_r[WIDTH-1:1]};
      // acc only keeps the WIDTH-1 bits already produced; the final bit goes straight to y
      acc_r   <= (WIDTH - 1)'({fa_sum_s, acc_r} >> 1);
      carry_r <= fa_co_s;
      cnt_r   <= cnt_r + CW'(1);
      if (cnt_r == CNT_PRE) begin
        cmsb_r <= fa_co_s;
      end
      if (last_s) begin
        y_r    <= {fa_sum_s, acc_r};
        co_r   <= fa_co_s;
        ovf_r  <= cmsb_r ^ fa_co_s;
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: directed operations against a cycle-level arithmetic model.
module tb_serial_add_sub;
  import serial_add_sub_pkg::*;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_add_sub_if #(.WIDTH(WIDTH)) bus_if ();

  serial_add_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result {ovf, co, y} from plain signed/unsigned integer arithmetic
  function automatic logic [WIDTH+1:0] calc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic sna);
    longint sa, sb, ua, ub, r, smax, smin;
    logic   c, v;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ua   = longint'(a);
    ub   = longint'(b);
    smax = (longint'(1) << (WIDTH - 1)) - 1;
    smin = -(longint'(1) << (WIDTH - 1));
    r    = sna ? sa - sb : sa + sb;
    c    = sna ? (ua >= ub) : ((ua + ub) >= (longint'(1) << WIDTH));
    v    = (r > smax) || (r < smin);
    return {v, c, r[WIDTH-1:0]};
  endfunction

  // Timing model: age counts edges since acceptance, -1 when able to accept
  int                 m_age = -1;
  logic [WIDTH+1:0]   m_res = '0;
  logic [WIDTH+1:0]   m_out = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_age <= -1;
      m_out <= '0;
    end else if (m_age < 0) begin
      if (bus_if.start) begin
        m_age <= 0;
        m_res <= calc(bus_if.a, bus_if.b, bus_if.sna);
      end
    end else if (m_age == WIDTH - 1) begin
      m_age <= WIDTH;
      m_out <= m_res;
    end else if (m_age == WIDTH) begin
      m_age <= -1;
    end else begin
      m_age <= m_age + 1;
    end
  end

  // Per-cycle compare; field order {ovf, co, busy, done, y}
  always @(negedge clk) begin : cmp
    logic eb, ed;
    if (chk_en) begin
      eb = (m_age >= 0) && (m_age < WIDTH);
      ed = (m_age == WIDTH);
      check("cycle{ovf,co,busy,done,y}",
            {bus_if.ovf, bus_if.co, bus_if.busy, bus_if.done, bus_if.y},
            {m_out[WIDTH+1], m_out[WIDTH], eb, ed, m_out[WIDTH-1:0]});
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after the FIN edge
  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sna, input logic [WIDTH-1:0] ey, input logic eco,
                        input logic eovf);
    int n;
    check({name, "_model"}, calc(a, b, sna), {eovf, eco, ey});
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.sna   = sna;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.done && n < 40);
    check({name, "_latency"}, 64'(n - 1), 64'(WIDTH));
    check({name, "_y"}, bus_if.y, ey);
    check({name, "_co_ovf"}, {bus_if.co, bus_if.ovf}, {eco, eovf});
    @(negedge clk);
    check({name, "_done_pulse"}, bus_if.done, 1'b0);
  endtask

  initial begin
    int dcount;
    int last_done;
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.sna   = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_y", bus_if.y, 32'h0);
    check("reset_flags", {bus_if.co, bus_if.ovf, bus_if.busy, bus_if.done}, 4'b0000);
    rst_n = 1'b1;

    run_op("add",      32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0);
    run_op("add_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("add_co",   32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("sub_pos",  32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 1'b1, 1'b0);
    run_op("sub_neg",  32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",  32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

    // START re-pulsed mid-run, on the DONE edge and during FIN; operands scrambled after acceptance
    bus_if.a     = 32'h12345678;
    bus_if.b     = 32'h11111111;
    bus_if.sna   = 1'b0;
    bus_if.start = 1'b1;
    @(posedge clk);
    dcount = 0;
    for (int i = 1; i <= 80; i++) begin
      #1;
      bus_if.start = (i == 5) || (i == 32) || (i == 33);
      bus_if.a     = $urandom;
      bus_if.b     = $urandom;
      bus_if.sna   = i[0];
      @(posedge clk);
      @(negedge clk);
      if (bus_if.done) dcount++;
    end
    bus_if.start = 1'b0;
    check("ignore_done_count", 64'(dcount), 64'd1);
    check("ignore_y", bus_if.y, 32'h23456789);

    // Reset in the middle of an operation
    bus_if.a     = 32'hAAAA0000;
    bus_if.b     = 32'h00005555;
    bus_if.sna   = 1'b0;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_y", bus_if.y, 32'h0);
    check("midrst_flags", {bus_if.co, bus_if.ovf, bus_if.busy, bus_if.done}, 4'b0000);
    rst_n = 1'b1;
    run_op("after_rst", 32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0);

    // START held high: an operation every WIDTH+2 cycles
    bus_if.start = 1'b1;
    dcount    = 0;
    last_done = -1;
    for (int i = 0; i < 140; i++) begin
      bus_if.a   = $urandom;
      bus_if.b   = $urandom;
      bus_if.sna = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      if (bus_if.done) begin
        dcount++;
        if (last_done >= 0) check("b2b_gap", 64'(i - last_done), 64'(WIDTH + 2));
        last_done = i;
      end
    end
    bus_if.start = 1'b0;
    check("b2b_done_count", 64'(dcount), 64'd4);
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
